// File: rtl/rename_pkg.sv
// Shared rename-stage sizing: physical/architectural register counts and free-list pointer types.
package rename_pkg;

  localparam int unsigned PREG_NUM     = 64;
  localparam int unsigned AREG_NUM     = 32;
  localparam int unsigned FL_DEPTH     = PREG_NUM - AREG_NUM;
  localparam int unsigned FETCH_WIDTH  = 2;
  localparam int unsigned COMMIT_WIDTH = 2;

  localparam int unsigned PREG_W   = $clog2(PREG_NUM);
  localparam int unsigned FL_IDX_W = $clog2(FL_DEPTH);
  localparam int unsigned FL_PTR_W = FL_IDX_W + 1;

  typedef logic [PREG_W-1:0]   preg_addr_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

endpackage

// File: rtl/popcount_compact.sv
// Counts set bits of a valid vector and gives each lane the number of set lanes below it.
module popcount_compact #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]            valid,
  output logic [CNT_W-1:0]            count,
  output logic [WIDTH-1:0][CNT_W-1:0] rank
);

  logic [CNT_W-1:0] acc;

  always_comb begin
    acc  = '0;
    rank = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rank[i] = acc;
      acc     = acc + CNT_W'(valid[i]);
    end
    count = acc;
  end

endmodule

// File: rtl/preg_freelist.sv
// Circular free list of physical register IDs with speculative head, committed head and tail;
// flush rewinds the speculative head to the committed head in one cycle.
module preg_freelist
  import rename_pkg::*;
#(
  parameter int unsigned ALLOC_WIDTH = FETCH_WIDTH,
  parameter int unsigned FREE_WIDTH  = COMMIT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ALLOC_WIDTH-1:0]       alloc_req,
  output logic                         alloc_ok,
  output preg_addr_t [ALLOC_WIDTH-1:0] alloc_id,
  input  logic [FREE_WIDTH-1:0]        commit_valid,
  input  preg_addr_t [FREE_WIDTH-1:0]  free_id,
  input  logic                         flush,
  output fl_ptr_t                      free_count,
  output logic                         empty
);

  localparam int unsigned A_CNT_W = $clog2(ALLOC_WIDTH + 1);
  localparam int unsigned F_CNT_W = $clog2(FREE_WIDTH + 1);

  preg_addr_t entry [FL_DEPTH];
  fl_ptr_t    head, chead, tail;
  fl_ptr_t    head_nxt, chead_nxt, tail_nxt, count_nxt;

  logic [A_CNT_W-1:0]                  n_req;
  logic [ALLOC_WIDTH-1:0][A_CNT_W-1:0] req_rank;
  logic [F_CNT_W-1:0]                  n_free;
  logic [FREE_WIDTH-1:0][F_CNT_W-1:0]  free_rank;
  logic [FL_IDX_W-1:0]                 rd_idx [ALLOC_WIDTH];
  logic [FL_IDX_W-1:0]                 wr_idx [FREE_WIDTH];

  popcount_compact #(.WIDTH(ALLOC_WIDTH), .CNT_W(A_CNT_W)) u_alloc_pc (
    .valid (alloc_req),
    .count (n_req),
    .rank  (req_rank)
  );

  popcount_compact #(.WIDTH(FREE_WIDTH), .CNT_W(F_CNT_W)) u_free_pc (
    .valid (commit_valid),
    .count (n_free),
    .rank  (free_rank)
  );

  assign free_count = tail - head;
  assign empty      = (free_count == '0);
  assign alloc_ok   = (n_req != '0) && (free_count >= FL_PTR_W'(n_req)) && !flush;

  // Compacted read/write slots: the k-th active lane uses pointer + k.
  always_comb begin
    for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
      rd_idx[i]   = head[FL_IDX_W-1:0] + FL_IDX_W'(req_rank[i]);
      alloc_id[i] = entry[rd_idx[i]];
    end
    for (int unsigned i = 0; i < FREE_WIDTH; i++) begin
      wr_idx[i] = tail[FL_IDX_W-1:0] + FL_IDX_W'(free_rank[i]);
    end
  end

  always_comb begin
    chead_nxt = chead + FL_PTR_W'(n_free);
    tail_nxt  = tail + FL_PTR_W'(n_free);
    head_nxt  = head;
    if (flush) begin
      head_nxt = chead_nxt;
    end else if (alloc_ok) begin
      head_nxt = head + FL_PTR_W'(n_req);
    end
    count_nxt = tail_nxt - head_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        entry[i] <= PREG_W'(AREG_NUM + i);
      end
      head  <= '0;
      chead <= '0;
      tail  <= FL_PTR_W'(FL_DEPTH);
    end else begin
      for (int unsigned i = 0; i < FREE_WIDTH; i++) begin
        if (commit_valid[i]) begin
          entry[wr_idx[i]] <= free_id[i];
        end
      end
      head  <= head_nxt;
      chead <= chead_nxt;
      tail  <= tail_nxt;
    end
  end

  // Releasing more registers than were handed out would corrupt the pool.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
                                   count_nxt <= FL_PTR_W'(FL_DEPTH))
    else $fatal(1, "preg_freelist: free list overflow");

endmodule

// File: tb/tb_preg_freelist.sv
// Self-checking bench for preg_freelist: directed scenarios plus random traffic against a queue model.
module tb_preg_freelist;
  import rename_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       alloc_req;
  logic             alloc_ok;
  preg_addr_t [1:0] alloc_id;
  logic [1:0]       commit_valid;
  preg_addr_t [1:0] free_id;
  logic             flush;
  fl_ptr_t          free_count;
  logic             empty;

  int tests = 0;
  int fails = 0;

  // Model: pool holds IDs from the committed head to the tail; spec = IDs handed out but not committed.
  int pool[$];
  int spec;
  bit m_ok;
  int m_id[2];

  always #5 clk = ~clk;

  preg_freelist dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_ok     (alloc_ok),
    .alloc_id     (alloc_id),
    .commit_valid (commit_valid),
    .free_id      (free_id),
    .flush        (flush),
    .free_count   (free_count),
    .empty        (empty)
  );

  function automatic int pc(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  function automatic int exp_fc();
    return pool.size() - spec;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; alloc_req = '0; commit_valid = '0; free_id = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    pool.delete();
    for (int i = 0; i < 32; i++) pool.push_back(32 + i);
    spec  = 0;
    reset = 1'b1;
  endtask

  // Applies inputs at the falling edge and computes the model's expected grant.
  task automatic drive(input logic [1:0] req, input logic [1:0] cv,
                       input int f0, input int f1, input logic fl);
    int k;
    @(negedge clk);
    alloc_req = req; commit_valid = cv; flush = fl;
    free_id[0] = PREG_W'(f0); free_id[1] = PREG_W'(f1);
    #1;
    m_ok = (pc(req) > 0) && (exp_fc() >= pc(req)) && !fl;
    k = 0;
    for (int l = 0; l < 2; l++) begin
      m_id[l] = -1;
      if (m_ok && req[l]) begin
        m_id[l] = pool[spec + k];
        k++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int l = 0; l < 2; l++) if (commit_valid[l]) pool.push_back(int'(free_id[l]));
    for (int l = 0; l < pc(commit_valid); l++) void'(pool.pop_front());
    spec = spec - pc(commit_valid) + (m_ok ? pc(alloc_req) : 0);
    if (flush) spec = 0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    tests++; if (free_count !== 6'd32) begin fails++; $display("FAIL reset_count: got %0d want 32", free_count); end
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL reset_empty: got %0b want 0", empty); end
    tests++; if (alloc_ok !== 1'b0) begin fails++; $display("FAIL reset_ok: got %0b want 0", alloc_ok); end
    tick();
  endtask

  task automatic test_first_alloc();
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    tests++; if (alloc_ok !== 1'b1) begin fails++; $display("FAIL first_ok: got %0b want 1", alloc_ok); end
    tests++; if (alloc_id[0] !== 6'd32 || alloc_id[1] !== 6'd33) begin
      fails++; $display("FAIL first_ids: got %0d,%0d want 32,33", alloc_id[0], alloc_id[1]); end
    tick();
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    tests++; if (free_count !== 6'd30) begin fails++; $display("FAIL first_count: got %0d want 30", free_count); end
    tick();
  endtask

  task automatic test_compaction();
    do_reset();
    drive(2'b10, 2'b00, 0, 0, 1'b0);
    tests++; if (alloc_ok !== 1'b1 || alloc_id[1] !== 6'd32) begin
      fails++; $display("FAIL compact_lane1: got ok=%0b id=%0d want ok=1 id=32", alloc_ok, alloc_id[1]); end
    tick();
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    tests++; if (free_count !== 6'd31) begin fails++; $display("FAIL compact_count: got %0d want 31", free_count); end
    tick();
  endtask

  task automatic test_drain_empty();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(2'b11, 2'b00, 0, 0, 1'b0);
      tests++; if (alloc_ok !== 1'b1 || alloc_id[0] !== PREG_W'(m_id[0]) || alloc_id[1] !== PREG_W'(m_id[1])) begin
        fails++; $display("FAIL drain_ids: got ok=%0b %0d,%0d want ok=1 %0d,%0d",
                          alloc_ok, alloc_id[0], alloc_id[1], m_id[0], m_id[1]); end
      tick();
    end
    drive(2'b01, 2'b00, 0, 0, 1'b0);
    tests++; if (free_count !== 6'd0 || empty !== 1'b1) begin
      fails++; $display("FAIL drain_empty: got count=%0d empty=%0b want 0,1", free_count, empty); end
    tests++; if (alloc_ok !== 1'b0) begin fails++; $display("FAIL empty_stall: got %0b want 0", alloc_ok); end
    tick();
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    tests++; if (free_count !== 6'd0) begin fails++; $display("FAIL stall_head: got %0d want 0", free_count); end
    tick();
  endtask

  task automatic test_partial_grant();
    drive(2'b00, 2'b01, 3, 0, 1'b0);
    tick();
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    tests++; if (free_count !== 6'd1 || alloc_ok !== 1'b0) begin
      fails++; $display("FAIL partial_deny: got count=%0d ok=%0b want 1,0", free_count, alloc_ok); end
    tick();
    drive(2'b00, 2'b01, 4, 0, 1'b0);
    tick();
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    tests++; if (free_count !== 6'd2 || alloc_ok !== 1'b1) begin
      fails++; $display("FAIL partial_grant: got count=%0d ok=%0b want 2,1", free_count, alloc_ok); end
    tests++; if (alloc_id[0] !== 6'd3 || alloc_id[1] !== 6'd4) begin
      fails++; $display("FAIL partial_ids: got %0d,%0d want 3,4", alloc_id[0], alloc_id[1]); end
    tick();
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    tick();
    drive(2'b11, 2'b11, 7, 5, 1'b0);
    tests++; if (free_count !== 6'd30 || alloc_id[0] !== 6'd34 || alloc_id[1] !== 6'd35) begin
      fails++; $display("FAIL same_pre: got count=%0d ids=%0d,%0d want 30 34,35", free_count, alloc_id[0], alloc_id[1]); end
    tick();
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    tests++; if (free_count !== 6'd30) begin fails++; $display("FAIL same_count: got %0d want 30", free_count); end
    tick();
    for (int c = 0; c < 14; c++) begin
      drive(2'b11, 2'b00, 0, 0, 1'b0);
      tests++; if (alloc_id[0] !== PREG_W'(m_id[0]) || alloc_id[1] !== PREG_W'(m_id[1])) begin
        fails++; $display("FAIL same_walk: got %0d,%0d want %0d,%0d", alloc_id[0], alloc_id[1], m_id[0], m_id[1]); end
      tick();
    end
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    tests++; if (alloc_ok !== 1'b1 || alloc_id[0] !== 6'd7 || alloc_id[1] !== 6'd5) begin
      fails++; $display("FAIL same_wrap: got ok=%0b %0d,%0d want 1 7,5", alloc_ok, alloc_id[0], alloc_id[1]); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    drive(2'b11, 2'b00, 0, 0, 1'b0); tick();
    drive(2'b11, 2'b00, 0, 0, 1'b0); tick();
    drive(2'b11, 2'b11, 1, 2, 1'b0); tick();
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    tests++; if (free_count !== 6'd28) begin fails++; $display("FAIL flush_pre: got %0d want 28", free_count); end
    tick();
    drive(2'b11, 2'b01, 9, 0, 1'b1);
    tests++; if (alloc_ok !== 1'b0) begin fails++; $display("FAIL flush_ok: got %0b want 0", alloc_ok); end
    tick();
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    tests++; if (free_count !== 6'd32) begin fails++; $display("FAIL flush_count: got %0d want 32", free_count); end
    tick();
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    tests++; if (alloc_ok !== 1'b1 || alloc_id[0] !== 6'd35 || alloc_id[1] !== 6'd36) begin
      fails++; $display("FAIL flush_reissue: got ok=%0b %0d,%0d want 1 35,36", alloc_ok, alloc_id[0], alloc_id[1]); end
    tick();
  endtask

  task automatic test_async_reset();
    drive(2'b11, 2'b00, 0, 0, 1'b0); tick();
    @(negedge clk);
    alloc_req = '0;
    #2 reset = 1'b0;
    #1;
    tests++; if (free_count !== 6'd32) begin fails++; $display("FAIL async_reset: got %0d want 32", free_count); end
    do_reset();
  endtask

  task automatic test_random();
    logic [1:0] req, cv;
    logic       fl;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req = 2'($urandom);
      cv  = 2'($urandom);
      fl  = ($urandom_range(0, 15) == 0);
      if (spec == 0) cv = 2'b00;
      else if (spec == 1 && cv == 2'b11) cv = 2'($urandom_range(1, 2));
      drive(req, cv, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), fl);
      tests++; if (free_count !== PREG_W'(exp_fc()) || empty !== (exp_fc() == 0)) begin
        fails++; $display("FAIL rnd_count[%0d]: got %0d/%0b want %0d", c, free_count, empty, exp_fc()); end
      tests++; if (alloc_ok !== m_ok) begin
        fails++; $display("FAIL rnd_ok[%0d]: got %0b want %0b", c, alloc_ok, m_ok); end
      for (int l = 0; l < 2; l++) begin
        if (m_ok && req[l]) begin
          tests++; if (alloc_id[l] !== PREG_W'(m_id[l])) begin
            fails++; $display("FAIL rnd_id[%0d] lane%0d: got %0d want %0d", c, l, alloc_id[l], m_id[l]); end
        end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; alloc_req = '0; commit_valid = '0; free_id = '0; flush = 1'b0;
    test_reset();
    test_first_alloc();
    test_compaction();
    test_drain_empty();
    test_partial_grant();
    test_same_cycle();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
